// File: rtl/f1_lights_seq.sv
// Formula-1 start-light sequencer: fills lights on en ticks, holds all lit,
// then times the driver's reaction from lights-out to button press.
module f1_lights_seq #(
  parameter int unsigned N_LIGHTS = 8,
  parameter int unsigned HOLD_W   = 7,
  parameter int unsigned REACT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                trigger,
  input  logic [HOLD_W-1:0]   hold_ticks,
  input  logic                button,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                cmd_seq,
  output logic                cmd_delay,
  output logic                go,
  output logic                jump_start,
  output logic [REACT_W-1:0]  react_count,
  output logic                react_valid
);

  localparam int unsigned KW = $clog2(N_LIGHTS + 1);
  localparam logic [KW-1:0] KMax = KW'(N_LIGHTS);
  localparam logic [REACT_W-1:0] ReactMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StHold,
    StTiming,
    StDone,
    StFault
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [REACT_W-1:0]  react_q, react_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      hold_q  <= '0;
      react_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hold_q  <= hold_d;
      react_q <= react_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    react_d = react_q;
    case (state_q)
      StIdle, StDone, StFault: begin
        // Button is ignored here, so a coincident trigger always restarts.
        if (trigger) begin
          state_d = StFill;
          k_d     = KW'(1);
          hold_d  = hold_ticks;
          react_d = '0;
        end
      end
      StFill: begin
        if (button) begin
          state_d = StFault;
          k_d     = '0;
        end else if (en) begin
          if (k_q < KMax) begin
            k_d = k_q + KW'(1);
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (button) begin
          state_d = StFault;
          k_d     = '0;
        end else if (en) begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else begin
            state_d = StTiming;
            k_d     = '0;
            react_d = '0;
          end
        end
      end
      StTiming: begin
        if (button) begin
          state_d = StDone;
        end else if (react_q != ReactMax) begin
          react_d = react_q + REACT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Everything below decodes registered state only.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      data_out[i] = (state_q == StHold) || ((state_q == StFill) && (i < int'(k_q)));
    end
  end

  assign cmd_seq     = (state_q == StFill);
  assign cmd_delay   = (state_q == StHold);
  assign go          = (state_q == StTiming) && (react_q == '0);
  assign jump_start  = (state_q == StFault);
  assign react_valid = (state_q == StDone);
  assign react_count = react_q;

endmodule

// File: tb/tb_f1_lights_seq.sv
// Bench for f1_lights_seq: directed vector table, hand sequences for long
// corner cases, and randomized stimulus against a behavioural model.
module tb_f1_lights_seq;

  localparam int N  = 8;
  localparam int HW = 7;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en, trigger, button;
  logic [HW-1:0] hold_ticks;
  logic [N-1:0]  data_out;
  logic          cmd_seq, cmd_delay, go, jump_start, react_valid;
  logic [RW-1:0] react_count;

  logic          en_s, trigger_s, button_s;
  logic [HW-1:0] hold_ticks_s;
  logic [0:0]    data_out_s;
  logic          cmd_seq_s, cmd_delay_s, go_s, jump_start_s, react_valid_s;
  logic [3:0]    react_count_s;

  f1_lights_seq #(.N_LIGHTS(N), .HOLD_W(HW), .REACT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trigger(trigger), .hold_ticks(hold_ticks),
    .button(button), .data_out(data_out), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .go(go), .jump_start(jump_start), .react_count(react_count), .react_valid(react_valid)
  );

  f1_lights_seq #(.N_LIGHTS(1), .HOLD_W(HW), .REACT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en_s), .trigger(trigger_s), .hold_ticks(hold_ticks_s),
    .button(button_s), .data_out(data_out_s), .cmd_seq(cmd_seq_s), .cmd_delay(cmd_delay_s),
    .go(go_s), .jump_start(jump_start_s), .react_count(react_count_s),
    .react_valid(react_valid_s)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          en, trg, btn;
    logic [HW-1:0] hold;
    logic [N-1:0]  d;
    logic          seq, dly, g, js, val;
    logic [RW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit e, bit t, bit b, int h, int d, bit s, bit dl, bit g,
                              bit j, bit v, int c);
    vec_t r;
    r.en = e; r.trg = t; r.btn = b; r.hold = HW'(h); r.d = N'(d);
    r.seq = s; r.dly = dl; r.g = g; r.js = j; r.val = v; r.cnt = RW'(c);
    return r;
  endfunction

  function automatic logic [63:0] act_main();
    return 64'({data_out, cmd_seq, cmd_delay, go, jump_start, react_valid, react_count});
  endfunction

  function automatic logic [63:0] exp_main(int d, bit s, bit dl, bit g, bit j, bit v, int c);
    return 64'({N'(d), s, dl, g, j, v, RW'(c)});
  endfunction

  function automatic logic [63:0] act_small();
    return 64'({data_out_s, cmd_seq_s, cmd_delay_s, go_s, jump_start_s, react_valid_s,
                react_count_s});
  endfunction

  function automatic logic [63:0] exp_small(int d, bit s, bit dl, bit g, int c);
    return 64'({1'(d), s, dl, g, 1'b0, 1'b0, 4'(c)});
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit e, bit t, bit b, int h);
    en = e; trigger = t; button = b; hold_ticks = HW'(h);
  endtask

  // Behavioural model: phase names, lit count and a countdown of hold ticks.
  localparam int PIdle = 0, PFill = 1, PHold = 2, PTime = 3, PDone = 4, PFault = 5;
  int m_ph, m_lit, m_left, m_cnt;
  bit m_fresh;

  task automatic model_step(bit e, bit t, bit b, int h);
    m_fresh = 0;
    if (m_ph == PIdle || m_ph == PDone || m_ph == PFault) begin
      if (t) begin m_ph = PFill; m_lit = 1; m_left = h; m_cnt = 0; end
    end else if (m_ph == PFill || m_ph == PHold) begin
      if (b) m_ph = PFault;
      else if (e && m_ph == PFill) begin
        if (m_lit < N) m_lit++;
        else m_ph = PHold;
      end else if (e) begin
        if (m_left > 0) m_left--;
        else begin m_ph = PTime; m_cnt = 0; m_fresh = 1; end
      end
    end else if (m_ph == PTime) begin
      if (b) m_ph = PDone;
      else if (m_cnt < (1 << RW) - 1) m_cnt++;
    end
  endtask

  function automatic logic [63:0] model_out();
    int d;
    d = (m_ph == PFill) ? (1 << m_lit) - 1 : (m_ph == PHold) ? (1 << N) - 1 : 0;
    return exp_main(d, m_ph == PFill, m_ph == PHold, m_fresh, m_ph == PFault, m_ph == PDone,
                    (m_ph == PTime || m_ph == PDone) ? m_cnt : 0);
  endfunction

  initial begin
    drive(0, 0, 0, 0);
    en_s = 0; trigger_s = 0; button_s = 0; hold_ticks_s = '0;

    // Fill, jump starts, en+button priority, trigger+button restart, full run.
    tbl.push_back(mk(0,0,0,0, 'h00, 0,0,0,0,0, 0));
    tbl.push_back(mk(1,0,1,0, 'h00, 0,0,0,0,0, 0));
    tbl.push_back(mk(0,1,0,5, 'h01, 1,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'h03, 1,0,0,0,0, 0));
    tbl.push_back(mk(0,1,0,0, 'h03, 1,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'h07, 1,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,0, 'h00, 0,0,0,1,0, 0));
    tbl.push_back(mk(1,0,0,0, 'h00, 0,0,0,1,0, 0));
    tbl.push_back(mk(1,0,1,0, 'h00, 0,0,0,1,0, 0));
    tbl.push_back(mk(0,1,0,0, 'h01, 1,0,0,0,0, 0));
    for (int i = 2; i <= N; i++) tbl.push_back(mk(1,0,0,0, (1 << i) - 1, 1,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'hFF, 0,1,0,0,0, 0));
    tbl.push_back(mk(1,0,1,0, 'h00, 0,0,0,1,0, 0));
    tbl.push_back(mk(0,1,1,2, 'h01, 1,0,0,0,0, 0));
    for (int i = 2; i <= N; i++) tbl.push_back(mk(1,0,0,0, (1 << i) - 1, 1,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'hFF, 0,1,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0, 'hFF, 0,1,0,0,0, 0));
    tbl.push_back(mk(1,1,0,0, 'hFF, 0,1,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'hFF, 0,1,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'h00, 0,0,1,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 'h00, 0,0,0,0,0, 1));
    tbl.push_back(mk(0,1,0,0, 'h00, 0,0,0,0,0, 2));

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("reset_state", act_main(), exp_main(0, 0,0,0,0,0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].trg, tbl[i].btn, int'(tbl[i].hold));
      tick();
      check($sformatf("vec%0d", i), act_main(),
            64'({tbl[i].d, tbl[i].seq, tbl[i].dly, tbl[i].g, tbl[i].js, tbl[i].val,
                 tbl[i].cnt}));
    end

    // Reaction timed 37 cycles after go, held through en/button until trigger.
    drive(0, 0, 0, 0);
    for (int c = 3; c <= 37; c++) begin
      tick();
      check($sformatf("timing_cnt%0d", c), act_main(), exp_main(0, 0,0,0,0,0, c));
    end
    drive(0, 0, 1, 0);
    tick();
    check("react_done", act_main(), exp_main(0, 0,0,0,0,1, 37));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, i[0], 0);
      tick();
      check("react_hold", act_main(), exp_main(0, 0,0,0,0,1, 37));
    end
    drive(0, 1, 0, 3);
    tick();
    check("retrigger_clears", act_main(), exp_main(1, 1,0,0,0,0, 0));
    drive(0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1 check("async_reset_fill", act_main(), exp_main(0, 0,0,0,0,0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single light, zero hold, narrow saturating counter.
    tick();
    trigger_s = 1;
    tick();
    check("s_trigger", act_small(), exp_small(1, 1,0,0, 0));
    trigger_s = 0; en_s = 1;
    tick();
    check("s_hold", act_small(), exp_small(1, 0,1,0, 0));
    tick();
    check("s_go", act_small(), exp_small(0, 0,0,1, 0));
    en_s = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("s_cnt%0d", c), act_small(), exp_small(0, 0,0,0, (c > 15) ? 15 : c));
    end
    #3 rst_n = 1'b0;
    #1 check("s_async_reset", act_small(), exp_small(0, 0,0,0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model.
    m_ph = PIdle; m_lit = 0; m_left = 0; m_cnt = 0; m_fresh = 0;
    for (int i = 0; i < 3000; i++) begin
      bit e, t, b;
      int h;
      e = ($urandom_range(0, 1) == 1);
      t = ($urandom_range(0, 15) == 0);
      b = ($urandom_range(0, 39) == 0);
      h = $urandom_range(0, 4);
      drive(e, t, b, h);
      tick();
      model_step(e, t, b, h);
      check($sformatf("rand%0d", i), act_main(), model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f1_lights_seq.md
F1_LIGHTS_SEQ -- requirements
Module: f1_lights_seq

Interface
REQ-001 The block SHALL have parameter N_LIGHTS, default 8, the number of lights, legal range 1..32.
REQ-002 The block SHALL have parameter HOLD_W, default 7, the width of the hold-time input.
REQ-003 The block SHALL have parameter REACT_W, default 16, the width of the reaction counter.
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port en  input  1  single-cycle tick strobe pacing FILL and HOLD.
REQ-007 The block SHALL have port trigger  input  1  start request.
REQ-008 The block SHALL have port hold_ticks  input  HOLD_W  all-lit hold length in en ticks, sampled on accepted trigger.
REQ-009 The block SHALL have port button  input  1  driver reaction input, level-sensitive, already synchronised.
REQ-010 The block SHALL have port data_out  output  N_LIGHTS  light pattern, bit 0 lights first.
REQ-011 The block SHALL have port cmd_seq  output  1  high while in FILL.
REQ-012 The block SHALL have port cmd_delay  output  1  high while in HOLD.
REQ-013 The block SHALL have port go  output  1  one-cycle pulse on lights-out.
REQ-014 The block SHALL have port jump_start  output  1  high while in FAULT.
REQ-015 The block SHALL have port react_count  output  REACT_W  clk cycles from lights-out to button.
REQ-016 The block SHALL have port react_valid  output  1  high while in DONE.

Function
REQ-017 States SHALL be IDLE, FILL, HOLD, TIMING, DONE and FAULT, with registered lit count k (0..N_LIGHTS), hold counter and reaction counter.
REQ-018 data_out SHALL be the low k bits set in FILL, all ones in HOLD, and all zeros in IDLE, TIMING, DONE and FAULT.
REQ-019 On trigger=1 in IDLE, DONE or FAULT the block SHALL enter FILL with k=1 and latch hold_ticks, visible the next cycle.
REQ-020 Trigger SHALL also clear react_count, react_valid and jump_start on that same transition.
REQ-021 Trigger SHALL be ignored in FILL, HOLD and TIMING.
REQ-022 In FILL, en=1 with k<N_LIGHTS SHALL increment k.
REQ-023 In FILL, en=1 with k==N_LIGHTS SHALL enter HOLD with the hold counter set to the latched value.
REQ-024 In HOLD, en=1 with the hold counter nonzero SHALL decrement it.
REQ-025 In HOLD, en=1 with the hold counter zero SHALL enter TIMING, so HOLD lasts latched+1 en ticks; latched=0 SHALL leave on the first en.
REQ-026 go SHALL be high exactly on the first cycle in TIMING, with react_count=0 in that cycle.
REQ-027 In TIMING, react_count SHALL increment every clk cycle, independent of en, and saturate at 2^REACT_W-1 without wrapping.
REQ-028 button=1 in TIMING SHALL enter DONE with react_count frozen at its current value (0 if pressed during the go cycle).
REQ-029 button=1 in FILL or HOLD SHALL enter FAULT (jump start) and SHALL take priority over a simultaneous en.
REQ-030 en SHALL be ignored in IDLE, TIMING, DONE and FAULT.
REQ-031 button SHALL be ignored in IDLE, DONE and FAULT.
REQ-032 A trigger coincident with button in DONE or FAULT SHALL enter FILL.
REQ-033 Outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE, k=0, hold counter=0, react_count=0 and all outputs to 0 in any state, including mid-sequence.
REQ-035 After rst_n rises, the first transition SHALL occur on the next rising clk edge that samples an accepted trigger.

Verification
REQ-036 N_LIGHTS=8, hold_ticks=2, trigger then continuous en -> data_out 01,03,...,FF on successive en ticks; cmd_delay for 3 en ticks; go one cycle; data_out=00.
REQ-037 button 37 clk cycles after go -> react_valid=1, react_count=37, and both held until the next trigger.
REQ-038 button while data_out=07 -> jump_start=1, data_out=00, and subsequent en has no effect; trigger -> FILL with data_out=01, jump_start=0.
REQ-039 button and en in the same HOLD cycle -> FAULT, not TIMING, and go never pulses.
REQ-040 REACT_W=4 with no button -> react_count stops at 15; then rst_n=0 mid-TIMING -> all outputs 0 immediately, without waiting for a clk edge.
REQ-041 hold_ticks=0, N_LIGHTS=1 -> trigger gives data_out=1; the first en enters HOLD; the second en pulses go.
